// File: rtl/rx_pkt_buf_sf.sv
// Store-and-forward RX frame buffer: frames become readable only after EOP commit; overflowing frames are dropped whole.
// Defining RX_PKT_BUF_STATS_EN adds the drop_cnt / rx_pkt_total saturating statistics ports.
module rx_pkt_buf_sf #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 11,
  parameter int ADDRDEPTH = 2048,
  parameter int MODWIDTH  = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 wr_valid,
  input  logic                 wr_sop,
  input  logic                 wr_eop,
  input  logic [MODWIDTH-1:0]  wr_mod,
  input  logic [DATAWIDTH-1:0] wr_data,
  output logic                 wr_drop,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 rd_sop,
  output logic                 rd_eop,
  output logic [MODWIDTH-1:0]  rd_mod,
  output logic [ADDRWIDTH:0]   pkt_cnt,
  output logic [ADDRWIDTH:0]   free_words
`ifdef RX_PKT_BUF_STATS_EN
  ,
  output logic [15:0]          drop_cnt,
  output logic [31:0]          rx_pkt_total
`endif
);

  localparam int WORDW = DATAWIDTH + MODWIDTH + 2;
  localparam logic [ADDRWIDTH:0] DEPTH   = (ADDRWIDTH+1)'(ADDRDEPTH);
  localparam logic [ADDRWIDTH:0] PTR_ONE = (ADDRWIDTH+1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [WORDW-1:0]     mem [ADDRDEPTH];
  logic [WORDW-1:0]     q;
  logic [ADDRWIDTH:0]   spec_wptr, commit_ptr, rptr;
  logic [ADDRWIDTH:0]   wr_ptr, wr_ptr_inc, rptr_inc;
  logic                 wr_start, wr_cont, wr_take, wr_full;
  logic                 we, drop_set, commit;
  logic                 ren, rd_acc, rd_last, more_pkts;
  logic [ADDRWIDTH-1:0] rd_addr;

  // A SOP always restarts at commit_ptr, abandoning any partial frame.
  assign wr_start   = wr_valid & wr_sop;
  assign wr_cont    = wr_valid & ~wr_sop & (w_state == W_FRAME);
  assign wr_take    = wr_start | wr_cont;
  assign wr_ptr     = wr_start ? commit_ptr : spec_wptr;
  assign wr_ptr_inc = wr_ptr + PTR_ONE;
  assign wr_full    = ((wr_ptr - rptr) == DEPTH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    if (wr_take) begin
      if (wr_eop)       w_next = W_IDLE;
      else if (wr_full) w_next = W_DROP;
      else              w_next = W_FRAME;
    end else if (wr_valid && wr_eop && (w_state == W_DROP)) begin
      w_next = W_IDLE;
    end
  end

  always_comb begin
    we       = 1'b0;
    drop_set = 1'b0;
    commit   = 1'b0;
    if (wr_take) begin
      if (wr_full) begin
        drop_set = 1'b1;
      end else begin
        we     = 1'b1;
        commit = wr_eop;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spec_wptr  <= '0;
      commit_ptr <= '0;
      wr_drop    <= 1'b0;
    end else begin
      wr_drop <= drop_set;
      if (drop_set) begin
        spec_wptr <= commit_ptr;
      end else if (we) begin
        spec_wptr <= wr_ptr_inc;
        if (commit) commit_ptr <= wr_ptr_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem[wr_ptr[ADDRWIDTH-1:0]] <= {wr_sop, wr_eop, wr_mod, wr_data};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (ren)  q <= mem[rd_addr];
  end

  assign rd_sop  = q[WORDW-1];
  assign rd_eop  = q[WORDW-2];
  assign rd_mod  = q[DATAWIDTH +: MODWIDTH];
  assign rd_data = q[DATAWIDTH-1:0];

  assign rptr_inc  = rptr + PTR_ONE;
  assign rd_acc    = (r_state == R_STREAM) & rd_ready;
  assign rd_last   = rd_acc & rd_eop;
  assign more_pkts = (pkt_cnt > PTR_ONE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:   if (pkt_cnt != '0) r_next = R_LOAD;
      R_LOAD:   r_next = R_STREAM;
      R_STREAM: if (rd_last && !more_pkts) r_next = R_IDLE;
      default:  r_next = R_IDLE;
    endcase
  end

  // Prefetch the next word on the accepting cycle so streaming has no bubble.
  always_comb begin
    ren      = 1'b0;
    rd_addr  = rptr[ADDRWIDTH-1:0];
    rd_valid = 1'b0;
    case (r_state)
      R_IDLE: ren = (pkt_cnt != '0);
      R_STREAM: begin
        rd_valid = 1'b1;
        if (rd_acc && (!rd_eop || more_pkts)) begin
          ren     = 1'b1;
          rd_addr = rptr_inc[ADDRWIDTH-1:0];
        end
      end
      default: ren = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rptr    <= '0;
      pkt_cnt <= '0;
    end else begin
      if (rd_acc) rptr <= rptr_inc;
      case ({commit, rd_last})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  assign free_words = DEPTH - (spec_wptr - rptr);

`ifdef RX_PKT_BUF_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt     <= '0;
      rx_pkt_total <= '0;
    end else begin
      if (drop_set && (drop_cnt != '1))   drop_cnt     <= drop_cnt + 16'd1;
      if (commit && (rx_pkt_total != '1)) rx_pkt_total <= rx_pkt_total + 32'd1;
    end
  end
`endif

endmodule
